// File: rtl/frame_stream_reader_pkg.sv
// frame_stream_reader_pkg
// Items shared by the read side and the write side of the frame buffer:
//   - state_t: frame sequencing states (IDLE, RUN, DRAIN)
//   - calc_beats: beats per frame for a square image
//   - calc_addr_width: beat address width for a given beat count
package frame_stream_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  function automatic int calc_beats(input int image_dim, input int pixels_per_beat);
    return (image_dim * image_dim) / pixels_per_beat;
  endfunction

  // A one-beat frame still needs a one-bit address.
  function automatic int calc_addr_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/frame_stream_reader_if.sv
// frame_stream_reader_if
// Bundles the frame-buffer read port and the AXI-Stream output of the reader.
//   rd_en / rd_addr       : read request to the frame buffer (reader drives)
//   rd_data               : buffer data, valid the cycle after rd_en (buffer drives)
//   m_axis_t*             : AXI-Stream beat, tready driven by the downstream sink
// Modports:
//   master : the frame reader
//   slave  : the frame buffer plus the stream sink
interface frame_stream_reader_if
  import frame_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = calc_addr_width(calc_beats(512, 16))
);

  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;

  logic [DATA_WIDTH-1:0] m_axis_tdata;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;
  logic                  m_axis_tlast;
  logic                  m_axis_tuser;

  modport master (
    output rd_en,
    output rd_addr,
    input  rd_data,
    output m_axis_tdata,
    output m_axis_tvalid,
    input  m_axis_tready,
    output m_axis_tlast,
    output m_axis_tuser
  );

  modport slave (
    input  rd_en,
    input  rd_addr,
    output rd_data,
    input  m_axis_tdata,
    input  m_axis_tvalid,
    output m_axis_tready,
    input  m_axis_tlast,
    input  m_axis_tuser
  );

endinterface

// File: rtl/frame_stream_reader_stream_fifo2.sv
// stream_fifo2
// Two-entry FIFO whose head is a register, so head_data/head_vld come
// straight from flops and stay stable while the head is not popped.
// Ports:
//   clk, aresetn : clock, synchronous active-low reset
//   push, push_data : write one entry
//   pop          : remove the head entry (only legal while head_vld)
//   occ          : current occupancy, 0..2
//   head_data, head_vld : oldest entry and its valid flag
module stream_fifo2 #(
  parameter int DATA_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [1:0]            occ,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic                  head_vld
);

  logic [DATA_WIDTH-1:0] slot0;
  logic [DATA_WIDTH-1:0] slot1;

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      occ   <= 2'd0;
      slot0 <= '0;
      slot1 <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) slot0 <= push_data;
          else             slot1 <= push_data;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          occ   <= occ - 2'd1;
        end
        // Simultaneous push and pop keep the occupancy; the new entry lands
        // behind whatever remains after the head leaves.
        2'b11: begin
          if (occ == 2'd2) begin
            slot0 <= slot1;
            slot1 <= push_data;
          end else begin
            slot0 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign head_data = slot0;
  assign head_vld  = (occ != 2'd0);

  a_no_overflow:  assert property (@(posedge clk) disable iff (!aresetn)
                                   !(push && !pop && occ == 2'd2));
  a_no_underflow: assert property (@(posedge clk) disable iff (!aresetn)
                                   !(pop && occ == 2'd0));

endmodule

// File: rtl/frame_stream_reader.sv
// frame_stream_reader
// Reads one full frame from a beat-organised frame buffer and emits it as
// an AXI-Stream master (tuser = start of frame, tlast = end of frame).
// Ports:
//   clk, aresetn : clock, synchronous active-low reset
//   start        : frame request, sampled only while idle
//   busy         : high whenever a frame is in progress
//   frame_done   : one-cycle pulse after the last beat handshake
//   bus          : frame_stream_reader_if.master (buffer read port + stream)
// Reads are throttled so that FIFO entries plus reads in flight never exceed
// two; the 1-cycle buffer latency is absorbed without losing beats under any
// tready pattern.
module frame_stream_reader
  import frame_stream_reader_pkg::*;
#(
  parameter int PIXELS_PER_BEAT = 16,
  parameter int IMAGE_DIM       = 512,
  parameter int BIT_WIDTH       = 8,
  parameter int DATA_WIDTH      = PIXELS_PER_BEAT * BIT_WIDTH
) (
  input  logic clk,
  input  logic aresetn,
  input  logic start,
  output logic busy,
  output logic frame_done,
  frame_stream_reader_if.master bus
);

  localparam int BEATS      = calc_beats(IMAGE_DIM, PIXELS_PER_BEAT);
  localparam int ADDR_WIDTH = calc_addr_width(BEATS);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(BEATS - 1);

  state_t                state_q;
  state_t                state_d;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic [ADDR_WIDTH-1:0] beat_cnt_q;
  logic                  vld_p1;
  logic                  pop;
  logic [2:0]            pending;
  logic [1:0]            fifo_occ;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic                  fifo_vld;
  logic                  tlast;
  logic                  tuser;

  assign pop   = fifo_vld && bus.m_axis_tready;
  // pop implies occ >= 1, so this never goes negative.
  assign pending = {1'b0, fifo_occ} + {2'b00, vld_p1} - {2'b00, pop};

  // Flags qualified by valid so they read 0 whenever no beat is presented.
  assign tlast = fifo_vld && (beat_cnt_q == LAST_ADDR);
  assign tuser = fifo_vld && (beat_cnt_q == '0);

  always_ff @(posedge clk) begin
    if (!aresetn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (rd_en && rd_addr_q == LAST_ADDR) state_d = DRAIN;
      DRAIN:   if (pop && tlast) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state_q != IDLE);
    rd_en = 1'b0;
    if (state_q == RUN) rd_en = (pending < 3'd2);
  end

  // Stage p0 -> p1: read issued, data returns from the buffer next cycle.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      rd_addr_q  <= '0;
      beat_cnt_q <= '0;
      vld_p1     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      vld_p1     <= rd_en;
      frame_done <= (state_q == DRAIN) && pop && tlast;
      if (state_q == IDLE) begin
        rd_addr_q  <= '0;
        beat_cnt_q <= '0;
      end else begin
        // Both counters saturate at the last beat; they restart from IDLE.
        if (rd_en && rd_addr_q != LAST_ADDR) rd_addr_q <= rd_addr_q + ADDR_WIDTH'(1);
        if (pop && beat_cnt_q != LAST_ADDR)  beat_cnt_q <= beat_cnt_q + ADDR_WIDTH'(1);
      end
    end
  end

  // Stage p1 -> output: returned data queued, head presented on the stream.
  stream_fifo2 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .aresetn   (aresetn),
    .push      (vld_p1),
    .push_data (bus.rd_data),
    .pop       (pop),
    .occ       (fifo_occ),
    .head_data (fifo_head),
    .head_vld  (fifo_vld)
  );

  assign bus.rd_en         = rd_en;
  assign bus.rd_addr       = rd_addr_q;
  assign bus.m_axis_tdata  = fifo_head;
  assign bus.m_axis_tvalid = fifo_vld;
  assign bus.m_axis_tlast  = tlast;
  assign bus.m_axis_tuser  = tuser;

endmodule
